// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: opcode values, driver FSM
// encoding and the layout of a response FIFO entry.
package alu_pkg;

    localparam logic [7:0] OP_ADD = 8'd0;
    localparam logic [7:0] OP_SUB = 8'd1;
    localparam logic [7:0] OP_MUL = 8'd2;
    localparam logic [7:0] OP_DIV = 8'd3;
    localparam logic [7:0] OP_AND = 8'd4;

    localparam int RSP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } drv_state_e;

    // A FIFO entry carries the opcode in the upper byte and the result below.
    function automatic logic [RSP_W-1:0] pack_rsp(input logic [7:0] op,
                                                  input logic [7:0] res);
        return {op, res};
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Response FIFO holding {opcode, result} pairs; DEPTH must be a power of two
// so the pointers wrap by simple overflow.
module alu_rsp_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [RSP_W-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [RSP_W-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [RSP_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_MAX);
    assign empty   = (count_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            // A simultaneous push and pop leaves the occupancy unchanged.
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = !empty;
    assign head_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/alu_cmd_driver.sv
// Drives one command at a time onto a pipelined ALU, waits LATENCY clocks for
// the registered result and queues {opcode, result} for the host.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic [7:0] alu_ui,
    output logic [7:0] alu_op,
    input  logic [7:0] alu_res,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [7:0] rsp_op,
    output logic       busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FIFO_MAX = CW'(DEPTH);
    localparam logic [2:0]    LAT_LOAD = 3'(LATENCY);

    drv_state_e       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [7:0]       ui_q, ui_d;
    logic [7:0]       op_q, op_d;
    logic             push;
    logic             accept;
    logic             fifo_valid;
    logic [RSP_W-1:0] fifo_head;
    logic [CW-1:0]    fifo_count;

    // Ready depends only on registered state and reset, never on rsp_ready.
    assign cmd_ready = (state_q == ST_IDLE) && (fifo_count < FIFO_MAX) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ui_d    = ui_q;
        op_d    = op_q;
        push    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT_LOAD;
                    ui_d    = {cmd_b, cmd_a};
                    op_d    = cmd_op;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                push    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ui_q    <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ui_q    <= ui_d;
            op_q    <= op_d;
        end
    end

    alu_rsp_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (pack_rsp(op_q, alu_res)),
        .pop_i       (fifo_valid && rsp_ready),
        .valid_o     (fifo_valid),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign alu_ui    = ui_q;
    assign alu_op    = op_q;
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = fifo_valid;
    assign {rsp_op, rsp_data} = fifo_head;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: a behavioural LATENCY=1 ALU, directed commands and
// a scoreboard queue checked by an independent response monitor.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    localparam int LATENCY = 1;
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_op = '0;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic [7:0] alu_ui;
    logic [7:0] alu_op;
    logic [7:0] alu_res = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [7:0] rsp_op;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    logic [15:0] expq [$];
    logic [15:0] expHead;

    typedef struct packed {
        logic [7:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] res;
    } vec_t;

    vec_t wrapVecs [10] = '{
        '{8'h00, 4'h9, 4'h8, 8'h11},
        '{8'h01, 4'h7, 4'h3, 8'h04},
        '{8'h02, 4'h5, 4'h6, 8'h1E},
        '{8'h03, 4'hC, 4'h3, 8'h04},
        '{8'h03, 4'h7, 4'h0, 8'hFF},
        '{8'h04, 4'hC, 4'hA, 8'h08},
        '{8'h55, 4'h1, 4'h2, 8'h21},
        '{8'h00, 4'hF, 4'hF, 8'h1E},
        '{8'h01, 4'h0, 4'h1, 8'hFF},
        '{8'h02, 4'h3, 4'h7, 8'h15}
    };

    alu_cmd_driver #(
        .LATENCY(LATENCY),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_ui    (alu_ui),
        .alu_op    (alu_op),
        .alu_res   (alu_res),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_op    (rsp_op),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Registered ALU with one clock from operand pins to result; B=0 divides give 0xFF.
    function automatic logic [7:0] aluModel(input logic [7:0] op, input logic [7:0] ui);
        logic [7:0] a;
        logic [7:0] b;
        a = {4'h0, ui[3:0]};
        b = {4'h0, ui[7:4]};
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_DIV:  return (b == 8'h00) ? 8'hFF : a / b;
            OP_AND:  return a & b;
            default: return ui;
        endcase
    endfunction

    always @(posedge clk) alu_res <= aluModel(alu_op, alu_ui);

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: timed out, got no progress, expected completion", name);
    endtask

    // Every handshake seen at the falling edge must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_rsp: got 0x%0h, expected no response", {rsp_op, rsp_data});
            end else begin
                expHead = expq.pop_front();
                checkOutput("rsp", {rsp_op, rsp_data}, expHead);
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1ns after a rising edge; returns 1ns after the accepting edge.
    task automatic applyStimulus(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b,
                                 input logic [7:0] expRes, input bit expectRsp);
        int n;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            reportTimeout("cmd_accept");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (expectRsp) expq.push_back({op, expRes});
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        rsp_ready = 1'b1;
        n = 0;
        while ((expq.size() != 0 || rsp_valid) && n < 100) begin
            waitCycles(1);
            n++;
        end
        if (expq.size() != 0 || rsp_valid) reportTimeout("drain");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        waitCycles(2);
        checkOutput("ready_in_reset", 16'(cmd_ready), 16'h0);
        rst = 1'b0;
        waitCycles(1);
        checkOutput("reset_busy",     16'(busy),      16'h0);
        checkOutput("reset_alu_ui",   16'(alu_ui),    16'h0);
        checkOutput("reset_alu_op",   16'(alu_op),    16'h0);
        checkOutput("reset_rsp_valid",16'(rsp_valid), 16'h0);
        checkOutput("reset_rsp_head", {rsp_op, rsp_data}, 16'h0);
        checkOutput("reset_ready",    16'(cmd_ready), 16'h1);

        // ADD 3+4 with latency observation.
        rsp_ready = 1'b1;
        applyStimulus(OP_ADD, 4'h3, 4'h4, 8'h07, 1'b1);
        checkOutput("add_alu_ui", 16'(alu_ui), 16'h0043);
        checkOutput("add_alu_op", 16'(alu_op), 16'h0000);
        checkOutput("lat_e0_valid", 16'(rsp_valid), 16'h0);
        checkOutput("lat_e0_busy",  16'(busy), 16'h1);
        waitCycles(1);
        checkOutput("lat_e1_valid", 16'(rsp_valid), 16'h0);
        checkOutput("lat_e1_busy",  16'(busy), 16'h1);
        waitCycles(1);
        checkOutput("lat_e2_valid", 16'(rsp_valid), 16'h1);
        checkOutput("lat_e2_busy",  16'(busy), 16'h0);
        drain();

        applyStimulus(OP_SUB, 4'h2, 4'h5, 8'hFD, 1'b1);
        applyStimulus(OP_MUL, 4'hF, 4'hF, 8'hE1, 1'b1);
        drain();

        // Unknown opcode packs {B,A}; operands must stay put.
        applyStimulus(8'h07, 4'hA, 4'h5, 8'h5A, 1'b1);
        checkOutput("pack_ui_e0", 16'(alu_ui), 16'h005A);
        waitCycles(1);
        checkOutput("pack_ui_wait", 16'(alu_ui), 16'h005A);
        checkOutput("pack_op_wait", 16'(alu_op), 16'h0007);
        drain();
        checkOutput("pack_ui_after", 16'(alu_ui), 16'h005A);
        checkOutput("empty_head", {rsp_op, rsp_data}, 16'h0);

        // Fill the FIFO with the host stalled.
        rsp_ready = 1'b0;
        applyStimulus(OP_ADD, 4'h1, 4'h2, 8'h03, 1'b1);
        applyStimulus(OP_ADD, 4'h2, 4'h2, 8'h04, 1'b1);
        applyStimulus(OP_SUB, 4'h9, 4'h4, 8'h05, 1'b1);
        applyStimulus(OP_MUL, 4'h2, 4'h3, 8'h06, 1'b1);
        waitCycles(2);
        checkOutput("full_count", 16'(dut.u_fifo.count_o), 16'd4);
        checkOutput("full_ready", 16'(cmd_ready), 16'h0);
        fork
            applyStimulus(8'h80, 4'h3, 4'h2, 8'h23, 1'b1);
            begin
                waitCycles(2);
                checkOutput("full_ready_hold", 16'(cmd_ready), 16'h0);
                rsp_ready = 1'b1;
                waitCycles(1);
                rsp_ready = 1'b0;
                checkOutput("ready_after_pop", 16'(cmd_ready), 16'h1);
                checkOutput("count_after_pop", 16'(dut.u_fifo.count_o), 16'd3);
            end
        join
        drain();

        // Reset during WAIT discards the command.
        applyStimulus(OP_ADD, 4'h1, 4'h1, 8'h02, 1'b0);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("rst_ready_low", 16'(cmd_ready), 16'h0);
        rst = 1'b0;
        checkOutput("rst_busy",   16'(busy),   16'h0);
        checkOutput("rst_alu_op", 16'(alu_op), 16'h0);
        checkOutput("rst_alu_ui", 16'(alu_ui), 16'h0);
        waitCycles(1);
        checkOutput("ready_after_rst", 16'(cmd_ready), 16'h1);
        waitCycles(4);
        checkOutput("rst_no_rsp", 16'(rsp_valid), 16'h0);
        checkOutput("rst_count",  16'(dut.u_fifo.count_o), 16'd0);

        // Hold count at 2 with a pop on every capture edge; pointers wrap repeatedly.
        rsp_ready = 1'b0;
        applyStimulus(OP_ADD, 4'h1, 4'h1, 8'h02, 1'b1);
        applyStimulus(OP_AND, 4'hF, 4'h3, 8'h03, 1'b1);
        waitCycles(2);
        checkOutput("pp_count_start", 16'(dut.u_fifo.count_o), 16'd2);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(wrapVecs[i].op, wrapVecs[i].a, wrapVecs[i].b, wrapVecs[i].res, 1'b1);
            waitCycles(1);
            rsp_ready = 1'b1;
            waitCycles(1);
            rsp_ready = 1'b0;
            checkOutput($sformatf("pp_count_%0d", i), 16'(dut.u_fifo.count_o), 16'd2);
        end
        drain();
        checkOutput("final_count", 16'(dut.u_fifo.count_o), 16'd0);
        checkOutput("final_head",  {rsp_op, rsp_data}, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_cmd_driver.md
ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

Interface
REQ-001 SHALL have parameter: LATENCY, 1, ALU clocks from registered operand/opcode pins to a valid result (1..7).
REQ-002 SHALL have parameter: DEPTH, 4, response FIFO entries (power of two, 2..8).
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port: cmd_valid  in  1  host command present.
REQ-006 SHALL have port: cmd_ready  out  1  driver accepts the command this cycle.
REQ-007 SHALL have port: cmd_op  in  8  ALU opcode.
REQ-008 SHALL have port: cmd_a  in  4  operand A.
REQ-009 SHALL have port: cmd_b  in  4  operand B.
REQ-010 SHALL have port: alu_ui  out  8  operand pins to ALU, packed {B,A}.
REQ-011 SHALL have port: alu_op  out  8  opcode pins to ALU.
REQ-012 SHALL have port: alu_res  in  8  ALU registered result.
REQ-013 SHALL have port: rsp_valid  out  1  FIFO head valid.
REQ-014 SHALL have port: rsp_ready  in  1  host pops the head.
REQ-015 SHALL have port: rsp_data  out  8  captured result at the FIFO head.
REQ-016 SHALL have port: rsp_op  out  8  opcode echoed with rsp_data.
REQ-017 SHALL have port: busy  out  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM IDLE -> WAIT -> CAPTURE -> IDLE.
REQ-019 SHALL assert cmd_ready only in IDLE with FIFO count < DEPTH and rst low.
REQ-020 SHALL compute cmd_ready from registered state only, with no combinational path from rsp_ready.
REQ-021 SHALL accept a command on an edge with cmd_valid && cmd_ready (edge E0): register alu_ui={cmd_b,cmd_a} and alu_op=cmd_op, enter WAIT, load the counter with LATENCY.
REQ-022 SHALL decrement the counter each edge in WAIT and enter CAPTURE when it reaches 0.
REQ-023 SHALL push {alu_op, alu_res} into the FIFO at the edge leaving CAPTURE (E0+LATENCY+1) and return to IDLE.
REQ-024 SHALL give rsp_valid a first assertion after E0+LATENCY+1, i.e. command-to-response latency is LATENCY+1 edges.
REQ-025 SHALL hold alu_ui and alu_op stable from acceptance until the next acceptance.
REQ-026 SHALL allow at most one command in flight; the next acceptance is possible in the cycle after CAPTURE.
REQ-027 SHALL pass results through unmodified and do no arithmetic; divide-by-zero and unknown opcodes are forwarded as returned by the ALU.
REQ-028 SHALL pop the head on an edge with rsp_valid && rsp_ready.
REQ-029 SHALL leave count unchanged on a simultaneous push and pop.
REQ-030 SHALL wrap read/write pointers modulo DEPTH.
REQ-031 SHALL drive rsp_valid low and rsp_data/rsp_op to 0 when the FIFO is empty.
REQ-032 SHALL hold cmd_ready low when the FIFO is full; a capture never occurs into a full FIFO, because acceptance requires free space and no other source pushes.

Reset
REQ-033 SHALL, on an edge with rst high, set state IDLE, counter 0, FIFO pointers and count 0, alu_ui=0x00, alu_op=0x00, busy=0, rsp_valid=0.
REQ-034 SHALL discard any in-flight command when rst asserts mid-WAIT or mid-CAPTURE, with no response ever produced.
REQ-035 SHALL ignore cmd_valid and rsp_ready in the reset cycle.

Structure
REQ-036 SHALL place opcode constants in shared package alu_pkg: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_AND=4, with any other value meaning pack {B,A}.
REQ-037 SHALL place the FSM state encoding in alu_pkg.
REQ-038 SHALL implement the response FIFO as sub-module alu_rsp_fifo (DEPTH entries of 16 bits, count output); FSM and counter stay in alu_cmd_driver.

Verification
REQ-039 SHALL verify, with a behavioural ALU model (LATENCY=1) on alu_ui/alu_op/alu_res: op 0, A=3, B=4 -> rsp_data=0x07, rsp_op=0x00, rsp_valid first high after E0+2.
REQ-040 SHALL verify: op 1, A=2, B=5 -> rsp_data=0xFD; op 2, A=0xF, B=0xF -> rsp_data=0xE1.
REQ-041 SHALL verify: op 7, A=0xA, B=0x5 -> alu_ui=0x5A held stable through WAIT, rsp_data=0x5A.
REQ-042 SHALL verify: rsp_ready=0 and 5 back-to-back commands -> 4 accepted, cmd_ready low with count=4; one pop restores cmd_ready next cycle; 5th response returned in order.
REQ-043 SHALL verify: rst for 1 cycle during WAIT -> no response, busy=0, alu_op=0x00, cmd_ready high the cycle after.
REQ-044 SHALL verify: simultaneous push and pop at count=2 -> count stays 2 and pointers wrap correctly across 10 transactions.
